// File: rtl/window_sum_pkg.sv
// Shared constants, fill-state encoding and sizing helper
// for the sliding-window adder.
package window_sum_pkg;

    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_FILLING = 2'd1,
        ST_FULL    = 2'd2
    } fill_state_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/window_sum_buf.sv
// Circular sample buffer: presents the oldest entry (the one
// about to be overwritten) and writes the new sample over it.
module window_sum_buf
    import window_sum_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en_i,
    input  logic              clr_i,
    input  logic [DATA_W-1:0] d_i,
    output logic [DATA_W-1:0] old_o
);

    localparam int PTR_W = (clog2(DEPTH) > 0) ? clog2(DEPTH) : 1;

    logic [PTR_W-1:0]  wp_q, wp_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    assign old_o = mem_q[wp_q];

    always_comb begin
        wp_d = wp_q;
        if (clr_i) begin
            wp_d = '0;
        end else if (wr_en_i) begin
            if (wp_q == PTR_W'(DEPTH - 1)) wp_d = '0;
            else                           wp_d = wp_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wp_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wp_q <= wp_d;
            if (clr_i) begin
                for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            end else if (wr_en_i) begin
                mem_q[wp_q] <= d_i;
            end
        end
    end

endmodule

// File: rtl/window_sum.sv
// Sliding-window adder over the last DEPTH accepted samples,
// with flush, fill tracking and wrap/saturate output.
module window_sum
    import window_sum_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 3,
    parameter int SUM_W    = 8,
    parameter int SATURATE = MODE_WRAP
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [DATA_W-1:0]          d,
    input  logic                       clear,
    output logic [SUM_W-1:0]           sum,
    output logic [clog2(DEPTH+1)-1:0]  fill,
    output logic                       full
);

    localparam int ACC_W  = DATA_W + clog2(DEPTH);
    localparam int FILL_W = clog2(DEPTH + 1);

    logic              accept;
    logic [DATA_W-1:0] old;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [SUM_W-1:0]  sum_q, sum_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    fill_state_e       state_q, state_d;

    assign accept = in_valid & ~clear;

    window_sum_buf #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH)
    ) u_buf (
        .clk    (clk),
        .reset  (reset),
        .wr_en_i(accept),
        .clr_i  (clear),
        .d_i    (d),
        .old_o  (old)
    );

    // The oldest entry is always part of acc, so the subtraction never underflows.
    always_comb begin
        acc_d = acc_q;
        if (clear)       acc_d = '0;
        else if (accept) acc_d = acc_q + ACC_W'(d) - ACC_W'(old);
    end

    if (ACC_W > SUM_W) begin : g_narrow
        always_comb begin
            sum_d = acc_d[SUM_W-1:0];
            if (SATURATE == MODE_SAT && |acc_d[ACC_W-1:SUM_W]) sum_d = '1;
        end
    end else begin : g_wide
        assign sum_d = SUM_W'(acc_d);
    end

    always_comb begin
        state_d = state_q;
        fill_d  = fill_q;
        if (clear) begin
            state_d = ST_EMPTY;
            fill_d  = '0;
        end else if (accept) begin
            unique case (state_q)
                ST_EMPTY: begin
                    fill_d  = FILL_W'(1);
                    state_d = (DEPTH == 1) ? ST_FULL : ST_FILLING;
                end
                ST_FILLING: begin
                    fill_d = fill_q + FILL_W'(1);
                    if (fill_d == FILL_W'(DEPTH)) state_d = ST_FULL;
                end
                ST_FULL: ;
                default: begin
                    state_d = ST_EMPTY;
                    fill_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q   <= '0;
            sum_q   <= '0;
            fill_q  <= '0;
            state_q <= ST_EMPTY;
        end else begin
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            fill_q  <= fill_d;
            state_q <= state_d;
        end
    end

    assign sum  = sum_q;
    assign fill = fill_q;
    assign full = (state_q == ST_FULL);

endmodule

// File: tb/tb_window_sum.sv
// Bench for window_sum: four parameterisations driven from
// one shared input stream.
module tb_window_sum;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       clear;
    logic [7:0] d;

    logic [7:0] sum_leg, sum_sat, sum_one;
    logic [6:0] sum_wide;
    logic [1:0] fill_leg, fill_sat;
    logic [3:0] fill_wide;
    logic [0:0] fill_one;
    logic       full_leg, full_sat, full_wide, full_one;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    window_sum #(.DATA_W(8), .DEPTH(3), .SUM_W(8), .SATURATE(0)) u_leg (
        .clk(clk), .reset(rst_n), .in_valid(in_valid), .d(d), .clear(clear),
        .sum(sum_leg), .fill(fill_leg), .full(full_leg));

    window_sum #(.DATA_W(8), .DEPTH(3), .SUM_W(8), .SATURATE(1)) u_sat (
        .clk(clk), .reset(rst_n), .in_valid(in_valid), .d(d), .clear(clear),
        .sum(sum_sat), .fill(fill_sat), .full(full_sat));

    window_sum #(.DATA_W(4), .DEPTH(8), .SUM_W(7), .SATURATE(0)) u_wide (
        .clk(clk), .reset(rst_n), .in_valid(in_valid), .d(d[3:0]), .clear(clear),
        .sum(sum_wide), .fill(fill_wide), .full(full_wide));

    window_sum #(.DATA_W(8), .DEPTH(1), .SUM_W(8), .SATURATE(0)) u_one (
        .clk(clk), .reset(rst_n), .in_valid(in_valid), .d(d), .clear(clear),
        .sum(sum_one), .fill(fill_one), .full(full_one));

    typedef struct {
        logic       v;
        logic       c;
        logic [7:0] dd;
        int         s_wrap;
        int         s_sat;
        int         fl;
        int         fu;
    } vec_t;

    vec_t tbl [14];
    int   exp_q [$];

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic cyc(input logic v, input logic c, input logic [7:0] dd);
        in_valid = v;
        clear    = c;
        d        = dd;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] lfsr;
        int h1, h2, e, got, ws;

        rst_n    = 1'b0;
        in_valid = 1'b0;
        clear    = 1'b0;
        d        = '0;
        #12;
        chk("rst_sum_leg", int'(sum_leg), 0);
        chk("rst_fill_leg", int'(fill_leg), 0);
        chk("rst_full_leg", int'(full_leg), 0);
        chk("rst_sum_wide", int'(sum_wide), 0);
        chk("rst_full_one", int'(full_one), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Legacy LFSR stream with scoreboard
        lfsr = 16'hACE1;
        h1 = 0;
        h2 = 0;
        for (int n = 0; n < 256; n++) begin
            e = (int'(lfsr[7:0]) + h1 + h2) % 256;
            exp_q.push_back(e);
            h2 = h1;
            h1 = int'(lfsr[7:0]);
            cyc(1'b1, 1'b0, lfsr[7:0]);
            if (exp_q.size() == 0) begin
                chk("sb_underflow", 1, 0);
            end else begin
                got = exp_q.pop_front();
                chk("legacy_sum", int'(sum_leg), got);
            end
            lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end

        // Overflow, gating and clear vectors
        tbl[0]  = '{1'b0, 1'b1, 8'd0,   0,   0,   0, 0};
        tbl[1]  = '{1'b1, 1'b0, 8'd200, 200, 200, 1, 0};
        tbl[2]  = '{1'b1, 1'b0, 8'd100, 44,  255, 2, 0};
        tbl[3]  = '{1'b1, 1'b0, 8'd50,  94,  255, 3, 1};
        tbl[4]  = '{1'b1, 1'b0, 8'd0,   150, 150, 3, 1};
        tbl[5]  = '{1'b1, 1'b0, 8'd0,   50,  50,  3, 1};
        tbl[6]  = '{1'b0, 1'b1, 8'd0,   0,   0,   0, 0};
        tbl[7]  = '{1'b1, 1'b0, 8'd10,  10,  10,  1, 0};
        tbl[8]  = '{1'b1, 1'b0, 8'd20,  30,  30,  2, 0};
        tbl[9]  = '{1'b0, 1'b0, 8'd77,  30,  30,  2, 0};
        tbl[10] = '{1'b0, 1'b0, 8'd0,   30,  30,  2, 0};
        tbl[11] = '{1'b0, 1'b0, 8'd5,   30,  30,  2, 0};
        tbl[12] = '{1'b1, 1'b1, 8'd99,  0,   0,   0, 0};
        tbl[13] = '{1'b1, 1'b0, 8'd5,   5,   5,   1, 0};
        for (int i = 0; i < 14; i++) begin
            cyc(tbl[i].v, tbl[i].c, tbl[i].dd);
            chk($sformatf("vec%0d_sum_wrap", i), int'(sum_leg), tbl[i].s_wrap);
            chk($sformatf("vec%0d_sum_sat", i), int'(sum_sat), tbl[i].s_sat);
            chk($sformatf("vec%0d_fill", i), int'(fill_leg), tbl[i].fl);
            chk($sformatf("vec%0d_full", i), int'(full_leg), tbl[i].fu);
        end

        // Wrap-around of an 8-deep window
        cyc(1'b0, 1'b1, 8'd0);
        for (int i = 1; i <= 12; i++) begin
            cyc(1'b1, 1'b0, 8'(i));
            ws = 0;
            for (int k = (i > 8 ? i - 7 : 1); k <= i; k++) ws += k;
            chk($sformatf("wide_sum%0d", i), int'(sum_wide), ws);
            chk($sformatf("wide_fill%0d", i), int'(fill_wide), (i < 8) ? i : 8);
            chk($sformatf("wide_full%0d", i), int'(full_wide), (i >= 8) ? 1 : 0);
        end
        chk("wide_final", int'(sum_wide), 68);

        // Single-entry window
        cyc(1'b0, 1'b1, 8'd0);
        chk("one_clr_full", int'(full_one), 0);
        cyc(1'b1, 1'b0, 8'd3);
        chk("one_sum_a", int'(sum_one), 3);
        chk("one_full_a", int'(full_one), 1);
        chk("one_fill_a", int'(fill_one), 1);
        cyc(1'b1, 1'b0, 8'd9);
        chk("one_sum_b", int'(sum_one), 9);
        chk("one_full_b", int'(full_one), 1);

        // Asynchronous reset while full
        cyc(1'b0, 1'b1, 8'd0);
        cyc(1'b1, 1'b0, 8'd1);
        cyc(1'b1, 1'b0, 8'd2);
        cyc(1'b1, 1'b0, 8'd3);
        in_valid = 1'b0;
        chk("pre_rst_sum", int'(sum_leg), 6);
        chk("pre_rst_full", int'(full_leg), 1);
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_sum", int'(sum_leg), 0);
        chk("async_rst_fill", int'(fill_leg), 0);
        chk("async_rst_full", int'(full_leg), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        cyc(1'b1, 1'b0, 8'd7);
        chk("post_rst_sum", int'(sum_leg), 7);
        chk("post_rst_fill", int'(fill_leg), 1);
        chk("post_rst_full", int'(full_leg), 0);

        in_valid = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
